// File: rtl/ft832_bus_tracer.sv
// FT832 bus tracer: logs CPU state/address changes with timestamps into a show-ahead FIFO,
// gated by a masked address trigger and a post-trigger event count.
module ft832_bus_tracer #(
    parameter int DEPTH = 64,
    parameter int TSW   = 16,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               cpu_state,
    input  logic [AW-1:0]            cpu_ad,
    input  logic [7:0]               cpu_db,
    input  logic                     cpu_rw,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [AW-1:0]            trig_addr,
    input  logic [AW-1:0]            trig_mask,
    input  logic [15:0]              post_cnt,
    output logic                     tv_o,
    output logic [TSW+AW+15:0]       tdat_o,
    input  logic                     tready_i,
    output logic [1:0]               trc_state,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = TSW + AW + 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trc_state_e;

    trc_state_e      state_r, state_nx_s;
    logic [5:0]      prev_state_r;
    logic [AW-1:0]   prev_ad_r;
    logic [TSW-1:0]  ts_r;
    logic [15:0]     remaining_r, remaining_nx_s;
    logic            unlimited_r, unlimited_nx_s;
    logic            gap_pending_r;
    logic            ovf_r;
    logic            tv_r;
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   level_r, level_nx_s;
    logic [DW-1:0]   mem_r [DEPTH];

    logic            evt_s, match_s, log_s, flush_s;
    logic            full_s, pop_s, push_s, drop_s;
    logic [DW-1:0]   entry_s;

    assign evt_s   = (cpu_state != prev_state_r) | (cpu_ad != prev_ad_r);
    assign match_s = evt_s & (((cpu_ad ^ trig_addr) & trig_mask) == '0);
    assign full_s  = (level_r == LW'(DEPTH));
    assign entry_s = {gap_pending_r, cpu_rw, cpu_state, cpu_ad, cpu_db, ts_r};

    // Trace controller next state: arm beats abort beats the normal flow.
    always_comb begin
        state_nx_s     = state_r;
        remaining_nx_s = remaining_r;
        unlimited_nx_s = unlimited_r;
        log_s          = 1'b0;
        flush_s        = 1'b0;
        if (arm) begin
            state_nx_s = ST_ARMED;
            flush_s    = 1'b1;
        end else if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = ST_IDLE;
                ST_ARMED: begin
                    if (match_s) begin
                        log_s          = 1'b1;
                        remaining_nx_s = post_cnt - 16'd1;
                        unlimited_nx_s = (post_cnt == 16'd0);
                        if (post_cnt == 16'd1) begin
                            state_nx_s = ST_DONE;
                        end else begin
                            state_nx_s = ST_CAPTURE;
                        end
                    end else begin
                        state_nx_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (evt_s) begin
                        log_s = 1'b1;
                        if (unlimited_r) begin
                            remaining_nx_s = remaining_r;
                        end else begin
                            // Dropped events also consume the budget.
                            remaining_nx_s = remaining_r - 16'd1;
                            if (remaining_r == 16'd1) begin
                                state_nx_s = ST_DONE;
                            end else begin
                                state_nx_s = ST_CAPTURE;
                            end
                        end
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                ST_DONE: state_nx_s = ST_DONE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FIFO handshake: a pop frees the slot, so a full FIFO still accepts a same-cycle push.
    always_comb begin
        pop_s      = tv_r & tready_i & ~flush_s;
        push_s     = log_s & (~full_s | pop_s);
        drop_s     = log_s & full_s & ~pop_s;
        level_nx_s = level_r;
        if (flush_s) begin
            level_nx_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_nx_s = level_r + LW'(1);
                2'b01:   level_nx_s = level_r - LW'(1);
                default: level_nx_s = level_r;
            endcase
        end
    end

    // Control, timestamp, change-detect and FIFO pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            prev_state_r  <= 6'd0;
            prev_ad_r     <= '0;
            ts_r          <= '0;
            remaining_r   <= 16'd0;
            unlimited_r   <= 1'b0;
            gap_pending_r <= 1'b0;
            ovf_r         <= 1'b0;
            tv_r          <= 1'b0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            level_r       <= '0;
        end else begin
            state_r      <= state_nx_s;
            prev_state_r <= cpu_state;
            prev_ad_r    <= cpu_ad;
            ts_r         <= ts_r + TSW'(1);
            remaining_r  <= remaining_nx_s;
            unlimited_r  <= unlimited_nx_s;
            level_r      <= level_nx_s;
            tv_r         <= (level_nx_s != '0);
            if (flush_s) begin
                wr_ptr_r      <= '0;
                rd_ptr_r      <= '0;
                ovf_r         <= 1'b0;
                gap_pending_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r      <= wr_ptr_r + PW'(1);
                    gap_pending_r <= 1'b0;
                end else if (drop_s) begin
                    ovf_r         <= 1'b1;
                    gap_pending_r <= 1'b1;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
        end
    end

    // Trace storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign tdat_o    = mem_r[rd_ptr_r];
    assign tv_o      = tv_r;
    assign trc_state = state_r;
    assign ovf       = ovf_r;
    assign level     = level_r;

endmodule

// File: tb/tb_ft832_bus_tracer.sv
// Directed bench for ft832_bus_tracer with a scoreboard of expected trace words.
module tb_ft832_bus_tracer;
    localparam int DEPTH = 8;
    localparam int TSW   = 16;
    localparam int AW    = 32;
    localparam int DW    = TSW + AW + 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [5:0]      cpu_state = 6'd0;
    logic [AW-1:0]   cpu_ad = '0;
    logic [7:0]      cpu_db = 8'd0;
    logic            cpu_rw = 1'b1;
    logic            arm = 1'b0;
    logic            abort = 1'b0;
    logic [AW-1:0]   trig_addr = '0;
    logic [AW-1:0]   trig_mask = '0;
    logic [15:0]     post_cnt = 16'd0;
    logic            tv_o;
    logic [DW-1:0]   tdat_o;
    logic            tready_i = 1'b1;
    logic [1:0]      trc_state;
    logic            ovf;
    logic [$clog2(DEPTH):0] level;

    logic [TSW-1:0]  ts_model;
    logic [DW-1:0]   sb[$];
    int              n_checks = 0;
    int              n_fail = 0;

    ft832_bus_tracer #(.DEPTH(DEPTH), .TSW(TSW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_state(cpu_state), .cpu_ad(cpu_ad),
        .cpu_db(cpu_db), .cpu_rw(cpu_rw), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .post_cnt(post_cnt),
        .tv_o(tv_o), .tdat_o(tdat_o), .tready_i(tready_i),
        .trc_state(trc_state), .ovf(ovf), .level(level)
    );

    always #5 clk = ~clk;

    // Reference cycle counter matching the free-running timestamp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_model <= '0;
        else        ts_model <= ts_model + 16'd1;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && tv_o === 1'b1 && tready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_word", tdat_o, '0);
                if (tdat_o === '0) begin
                    n_fail++;
                    $error("FAIL unexpected_word: observed %0h expected none", tdat_o);
                end
            end else begin
                check("trace_word", tdat_o, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic step(input logic [5:0] st, input logic [AW-1:0] ad, input logic [7:0] db,
                        input logic rw, input bit logged, input bit gap);
        tick();
        cpu_state = st; cpu_ad = ad; cpu_db = db; cpu_rw = rw;
        if (logged) sb.push_back({gap, rw, st, ad, db, ts_model});
    endtask

    task automatic pulse_arm(input logic [AW-1:0] ta, input logic [AW-1:0] tm,
                             input logic [15:0] pc, input logic [AW-1:0] ad);
        tick();
        arm = 1'b1; trig_addr = ta; trig_mask = tm; post_cnt = pc; cpu_ad = ad;
    endtask

    task automatic wait_empty();
        int k = 0;
        while (level !== '0 && k < 200) begin
            tick();
            k++;
        end
        check("drain_level", level, '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", trc_state, 2'd0);
        check("rst_tv", tv_o, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_level", level, '0);
        @(negedge clk) rst_n = 1'b1;

        // Mask 0, three events then DONE; a fourth change is ignored.
        step(6'h01, 32'h100, 8'h00, 1'b1, 0, 0);
        pulse_arm(32'h0, 32'h0, 16'd3, 32'h100);
        step(6'h01, 32'h101, 8'h11, 1'b1, 1, 0);
        step(6'h01, 32'h102, 8'h22, 1'b1, 1, 0);
        step(6'h01, 32'h103, 8'h33, 1'b1, 1, 0);
        tick();
        check("t1_done", trc_state, 2'd3);
        step(6'h01, 32'h104, 8'h44, 1'b1, 0, 0);
        wait_empty();
        check("t1_sb_empty", sb.size(), 0);

        // Masked trigger: only 0xFFFE matches.
        pulse_arm(32'h0000FFFC, 32'hFFFFFFFC, 16'd1, 32'h104);
        step(6'h01, 32'h10, 8'h01, 1'b1, 0, 0);
        step(6'h01, 32'h20, 8'h02, 1'b1, 0, 0);
        step(6'h01, 32'hFFFE, 8'h03, 1'b1, 1, 0);
        tick();
        check("t2_done", trc_state, 2'd3);
        wait_empty();

        // Overflow with consumer stalled, then a push+pop on a full FIFO.
        tready_i = 1'b0;
        pulse_arm(32'h0, 32'h0, 16'd0, 32'hFFFE);
        for (int i = 0; i < DEPTH + 2; i++)
            step(6'h01, 32'h200 + i, 8'(i), 1'b1, i < DEPTH, 0);
        tick();
        check("t3_level_full", level, DEPTH);
        check("t3_ovf", ovf, 1'b1);
        check("t3_capture", trc_state, 2'd2);
        step(6'h01, 32'h300, 8'h5A, 1'b1, 1, 1);
        tready_i = 1'b1;
        tick();
        check("t4_level_kept", level, DEPTH);
        check("t4_ovf_kept", ovf, 1'b1);
        wait_empty();
        check("t4_ovf_sticky", ovf, 1'b1);

        // Abort, then state-only changes and a write cycle; idle cycles log nothing.
        abort = 1'b1;
        tick();
        check("t5_abort_idle", trc_state, 2'd0);
        pulse_arm(32'h0, 32'h0, 16'd0, 32'h300);
        step(6'h05, 32'h300, 8'hA5, 1'b1, 1, 0);
        step(6'h06, 32'h300, 8'h3C, 1'b0, 1, 0);
        repeat (10) tick();
        wait_empty();
        check("t5_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-capture with data queued.
        tready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            step(6'h06, 32'h400 + i, 8'h00, 1'b1, 0, 0);
        tick();
        check("t6_level5", level, 5);
        check("t6_capture", trc_state, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tv", tv_o, 1'b0);
        check("t6_rst_level", level, '0);
        check("t6_rst_state", trc_state, 2'd0);
        check("t6_rst_ovf", ovf, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Arm while DONE flushes queued data; a same-cycle event is not logged.
        pulse_arm(32'h0, 32'h0, 16'd2, 32'h404);
        step(6'h06, 32'h500, 8'h00, 1'b1, 0, 0);
        step(6'h06, 32'h501, 8'h00, 1'b1, 0, 0);
        tick();
        check("t7_done", trc_state, 2'd3);
        check("t7_level2", level, 2);
        pulse_arm(32'h0, 32'h0, 16'd2, 32'h777);
        tick();
        check("t7_flush_level", level, '0);
        check("t7_flush_tv", tv_o, 1'b0);
        check("t7_armed", trc_state, 2'd1);
        tready_i = 1'b1;
        repeat (5) tick();
        check("t7_still_empty", level, '0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ft832_bus_tracer.md
Name: ft832_bus_tracer

Overview:
- Downstream consumer of the FT832 core's bus/state outputs on the NexysVideo build; hardware equivalent of the simulation bus monitor.
- Detects cycles where the CPU state or address bus changes, timestamps each event, and buffers it in a FIFO.
- FIFO drains over a valid/ready stream (UART/ILA bridge).
- Address-match trigger with mask and programmable post-trigger count.

Parameters:
- DEPTH, 64, FIFO entries; power of two, minimum 4.
- TSW, 16, timestamp width.
- AW, 32, CPU address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_state  in  6  CPU state machine code.
- cpu_ad  in  AW  CPU address bus.
- cpu_db  in  8  CPU data bus.
- cpu_rw  in  1  1 = read, 0 = write.
- arm  in  1  one-cycle pulse: flush FIFO, clear overflow, enter ARMED.
- abort  in  1  one-cycle pulse: return to IDLE; FIFO contents kept.
- trig_addr  in  AW  trigger address.
- trig_mask  in  AW  1 = bit compared.
- post_cnt  in  16  events to log including trigger event; 0 = unlimited.
- tv_o  out  1  trace word valid.
- tdat_o  out  TSW+AW+16  {gap, rw, state[5:0], ad, db, ts}.
- tready_i  in  1  consumer accepts the word.
- trc_state  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.
- ovf  out  1  sticky: an event was dropped.
- level  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: trc_state = IDLE, tv_o = 0, ovf = 0, level = 0, FIFO pointers = 0, prev_state/prev_ad = 0, ts = 0, remaining = 0, gap_pending = 0. tdat_o is don't-care while tv_o = 0.
- Timestamp ts: free-running, +1 every clk, wraps from all-ones to 0. It runs in every state.
- Change detection:
  - prev_state and prev_ad load every clk from the inputs.
  - event = (cpu_state != prev_state) | (cpu_ad != prev_ad), evaluated combinationally against the registered previous values.
  - The entry captures the current-cycle inputs and ts.
- Trigger match: match = event & (((cpu_ad ^ trig_addr) & trig_mask) == 0). With mask = 0, the first event matches.
- State machine:
  - IDLE: no logging. arm -> ARMED.
  - ARMED: on match, log the event and go to CAPTURE; remaining = post_cnt - 1. If post_cnt = 1, go to DONE instead of CAPTURE.
  - CAPTURE: log every event. When post_cnt != 0, decrement remaining per logged or dropped event; when an event occurs with remaining = 1, log it and go to DONE. When post_cnt = 0, stay in CAPTURE until abort/arm.
  - DONE: no logging; FIFO keeps draining. arm -> ARMED.
  - Priority, from any state: arm > abort > normal transition. arm flushes the FIFO (pointers and level to 0) in that cycle; an event in the same cycle is not logged.
  - post_cnt is sampled when the trigger fires; later changes are ignored.
- FIFO:
  - Show-ahead: tdat_o = entry at read pointer. tv_o = (level != 0).
  - Pop when tv_o & tready_i.
  - Push latency: event in cycle n -> tv_o may assert in cycle n+1.
  - Push and pop in the same cycle: both happen, level unchanged. This holds when full, so the push is accepted.
  - Push when full without a pop: entry is dropped, ovf set, gap_pending set, and the event still counts against remaining.
  - The next accepted entry carries gap = 1, then gap_pending clears.
  - Pointers wrap modulo DEPTH; level distinguishes full from empty.
- ovf and gap_pending clear only on arm or reset.
- Asynchronous reset mid-capture: everything returns to reset values immediately, FIFO contents are lost, and tv_o deasserts without handshake.

Test Plan:
- Reset, arm with mask = 0, post_cnt = 3; cpu_ad steps 0x100, 0x101, 0x102, 0x103 on successive cycles, tready_i = 1 -> three words with ad 0x101..0x103 and consecutive ts; trc_state = DONE; fourth change not logged; level returns to 0.
- trig_addr = 0x0000FFFC, mask = 0xFFFFFFFC; addresses 0x10, 0x20, 0xFFFE -> first entry ad = 0xFFFE; earlier changes absent.
- tready_i = 0, post_cnt = 0, DEPTH + 2 events -> level = DEPTH, ovf = 1. Raise tready_i, then one more event -> first DEPTH words have gap = 0; the word for the new event has gap = 1.
- Full FIFO, same cycle pop and event -> level stays DEPTH; new entry accepted; ovf unchanged.
- Only cpu_state changes while ad is constant -> event logged with correct state and rw; write cycle shows rw = 0. No change for 10 cycles -> nothing logged.
- rst_n low mid-CAPTURE with level = 5 -> tv_o = 0, level = 0, trc_state = IDLE, ovf = 0 immediately. Separately, arm while DONE with data queued -> FIFO flushed and state = ARMED.
